// File: rtl/huff_pkg.sv
// Shared types and canonical-code tables for the Huffman stream decoder.
// Tables are indexed by codeword length (1..CODE_LEN); the symbol order maps canonical rank to value.
package huff_pkg;

  localparam int unsigned CODE_LEN = 9;
  localparam int unsigned SYM_W    = 4;
  localparam int unsigned LEN_W    = 4;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_DECODE,
    ST_ERR
  } state_e;

  // First canonical code of each length (length 2 is empty, value only keeps the sequence canonical)
  localparam logic [CODE_LEN-1:0] FIRST_CODE [1:CODE_LEN] = '{
    9'd0, 9'd2, 9'd4, 9'd12, 9'd28, 9'd60, 9'd124, 9'd252, 9'd508
  };

  localparam logic [CODE_LEN-1:0] CODE_COUNT [1:CODE_LEN] = '{
    9'd1, 9'd0, 9'd2, 9'd2, 9'd2, 9'd2, 9'd2, 9'd2, 9'd3
  };

  localparam logic [SYM_W-1:0] BASE_IDX [1:CODE_LEN] = '{
    4'd0, 4'd1, 4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13
  };

  localparam logic signed [SYM_W-1:0] SYM_ORDER [0:15] = '{
    4'sd0,  4'sd1, -4'sd1, 4'sd2, -4'sd2, 4'sd3, -4'sd3, 4'sd4,
    -4'sd4, 4'sd5, -4'sd5, 4'sd6, -4'sd6, 4'sd7, -4'sd7, -4'sd8
  };

endpackage

// File: rtl/huff_code_match.sv
// Combinational canonical-code matcher: finds the codeword at the head of the bit buffer.
// Only the first avail_i head bits are considered present.
module huff_code_match
  import huff_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic [CODE_LEN-1:0]     head_i,
  input  logic [CNT_W-1:0]        avail_i,
  output logic [LEN_W-1:0]        len_o,
  output logic signed [SYM_W-1:0] sym_o,
  output logic                    valid_o,
  output logic                    invalid_o
);

  logic [CODE_LEN-1:0] code;
  logic [SYM_W-1:0]    idx;
  logic                hit;

  // Shortest-first search; the code is prefix-free so at most one length hits
  always_comb begin
    len_o = '0;
    sym_o = '0;
    code  = '0;
    idx   = '0;
    hit   = 1'b0;
    for (int unsigned l = 1; l <= CODE_LEN; l++) begin
      code = head_i >> (CODE_LEN - l);
      if (!hit && (32'(avail_i) >= l) &&
          ((code - FIRST_CODE[l]) < CODE_COUNT[l])) begin
        hit   = 1'b1;
        len_o = LEN_W'(l);
        idx   = BASE_IDX[l] + SYM_W'(code - FIRST_CODE[l]);
        sym_o = SYM_ORDER[idx];
      end
    end
  end

  assign valid_o   = hit;
  assign invalid_o = (32'(avail_i) >= CODE_LEN) && (head_i == '1);

endmodule

// File: rtl/huff_stream_decoder.sv
// Streaming canonical Huffman decoder: variable-length chunks in, one signed symbol per cycle out.
// Define HUFF_SYMCNT_EN to add the 16-bit output-handshake counter sym_count.
module huff_stream_decoder
  import huff_pkg::*;
#(
  parameter int unsigned IN_W     = 4,
  parameter int unsigned MAX_CODE = 9,
  parameter int unsigned BUF_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sValid,
  output logic                       sReady,
  input  logic [IN_W-1:0]            in_bits,
  input  logic [$clog2(IN_W+1)-1:0]  in_len,
  output logic signed [SYM_W-1:0]    decodedData,
  output logic                       tvalid,
  input  logic                       tready,
  output logic                       err
`ifdef HUFF_SYMCNT_EN
  ,
  output logic [15:0]                sym_count
`endif
);

  localparam int unsigned LEN_IN_W = $clog2(IN_W + 1);
  localparam int unsigned CNT_W    = $clog2(BUF_W + 1);

  if (BUF_W < MAX_CODE + IN_W) begin : g_buf_too_small
    $error("huff_stream_decoder: BUF_W must be at least MAX_CODE + IN_W");
  end
  if (MAX_CODE < CODE_LEN) begin : g_code_too_short
    $error("huff_stream_decoder: MAX_CODE must cover the 9-bit codewords");
  end

  state_e                   state_q, state_d;
  logic [BUF_W-1:0]         buf_q, buf_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [SYM_W-1:0]  data_q, data_d;
  logic                     tvalid_q, tvalid_d;
  logic                     err_q, err_d;

  logic [LEN_IN_W-1:0]      len_in;
  logic [IN_W-1:0]          in_masked;
  logic                     accept;
  logic                     consume;
  logic [BUF_W-1:0]         shifted;
  logic [CNT_W-1:0]         cnt_after;
  logic [CNT_W-1:0]         ins_sh;

  logic [LEN_W-1:0]         cur_len, nxt_len;
  logic signed [SYM_W-1:0]  cur_sym, nxt_sym;
  logic                     cur_valid, nxt_valid;
  logic                     cur_invalid, nxt_invalid;
  logic                     match_unused;

  // Head of the registered buffer drives decode
  huff_code_match #(.CNT_W(CNT_W)) u_cur_match (
    .head_i    (buf_q[BUF_W-1 -: CODE_LEN]),
    .avail_i   (cnt_q),
    .len_o     (cur_len),
    .sym_o     (cur_sym),
    .valid_o   (cur_valid),
    .invalid_o (cur_invalid)
  );

  // Head of the next buffer classifies the next state
  huff_code_match #(.CNT_W(CNT_W)) u_nxt_match (
    .head_i    (buf_d[BUF_W-1 -: CODE_LEN]),
    .avail_i   (cnt_d),
    .len_o     (nxt_len),
    .sym_o     (nxt_sym),
    .valid_o   (nxt_valid),
    .invalid_o (nxt_invalid)
  );

  assign match_unused = ^{cur_valid, nxt_len, nxt_sym};

  assign sReady = (32'(cnt_q) + IN_W <= BUF_W) && (state_q != ST_ERR) && !reset;

  // Clamp the chunk length and zero any bits above it
  always_comb begin
    len_in    = (32'(in_len) > IN_W) ? LEN_IN_W'(IN_W) : in_len;
    in_masked = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      in_masked[i] = in_bits[i] && (i < 32'(len_in));
    end
  end

  // Buffer is MSB-aligned: consume shifts the head out, appended bits land right behind the survivors
  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    tvalid_d  = tvalid_q;
    shifted   = buf_q;
    cnt_after = cnt_q;
    ins_sh    = '0;
    accept    = sValid && sReady;
    consume   = (state_q == ST_DECODE) && (!tvalid_q || tready);

    if (tvalid_q && tready) begin
      tvalid_d = 1'b0;
    end
    if (consume) begin
      data_d    = cur_sym;
      tvalid_d  = 1'b1;
      shifted   = buf_q << cur_len;
      cnt_after = cnt_q - CNT_W'(cur_len);
    end

    buf_d = shifted;
    cnt_d = cnt_after;
    if (accept) begin
      ins_sh = CNT_W'(BUF_W) - cnt_after - CNT_W'(len_in);
      buf_d  = shifted | (BUF_W'(in_masked) << ins_sh);
      cnt_d  = cnt_after + CNT_W'(len_in);
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_FILL, ST_DECODE: begin
        if (nxt_invalid || cur_invalid) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (nxt_valid) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign decodedData = data_q;
  assign tvalid      = tvalid_q;
  assign err         = err_q;

`ifdef HUFF_SYMCNT_EN
  logic [15:0] sym_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_cnt_q <= '0;
    end else if (tvalid_q && tready) begin
      sym_cnt_q <= sym_cnt_q + 16'd1;
    end
  end

  assign sym_count = sym_cnt_q;
`endif

endmodule

// File: tb/tb_huff_stream_decoder.sv
// Self-checking bench for huff_stream_decoder: a bit-queue reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized symbol stream.
`timescale 1ns/1ps
module tb_huff_stream_decoder;

  localparam int IN_W  = 4;
  localparam int BUF_W = 16;
  localparam int LW    = $clog2(IN_W + 1);

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  sValid;
  logic                  sReady;
  logic [IN_W-1:0]       in_bits;
  logic [LW-1:0]         in_len;
  logic signed [3:0]     decodedData;
  logic                  tvalid;
  logic                  tready;
  logic                  err;
`ifdef HUFF_SYMCNT_EN
  logic [15:0]           sym_count;
`endif

  huff_stream_decoder #(.IN_W(IN_W), .MAX_CODE(9), .BUF_W(BUF_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .sValid      (sValid),
    .sReady      (sReady),
    .in_bits     (in_bits),
    .in_len      (in_len),
    .decodedData (decodedData),
    .tvalid      (tvalid),
    .tready      (tready),
    .err         (err)
`ifdef HUFF_SYMCNT_EN
    ,
    .sym_count   (sym_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stream bits in order, a one-entry output slot, sticky error
  bit               mq[$];
  logic             m_tv   = 1'b0;
  logic signed [3:0] m_data = 4'sd0;
  logic             m_err  = 1'b0;
  int               m_hs_cnt = 0;
  int               m_log[$];

  // 0 = incomplete, 1 = valid symbol, 2 = nine ones (invalid)
  function automatic int parse(output int len, output int sym);
    int k = 0;
    len = 0;
    sym = 0;
    while (k < 9 && k < mq.size() && mq[k]) k++;
    if (k == 9) begin len = 9; return 2; end
    if (k == mq.size()) return 0;
    if (k == 0) begin len = 1; sym = 0; return 1; end
    if (k == 8) begin len = 9; sym = -8; return 1; end
    if (k + 2 > mq.size()) return 0;
    len = k + 2;
    sym = mq[k+1] ? -k : k;
    return 1;
  endfunction

  function automatic bit m_ready();
    return (mq.size() + IN_W <= BUF_W) && !m_err && !reset;
  endfunction

  always @(posedge clk or posedge reset) begin
    int st, l, s, n;
    bit acc;
    if (reset) begin
      mq.delete();
      m_tv   = 1'b0;
      m_data = 4'sd0;
      m_err  = 1'b0;
      m_hs_cnt = 0;
    end else begin
      acc = sValid && m_ready();
      if (m_tv && tready) begin
        m_log.push_back(int'(m_data));
        m_hs_cnt++;
        m_tv = 1'b0;
      end
      if (!m_err && !m_tv) begin
        st = parse(l, s);
        if (st == 1) begin
          repeat (l) void'(mq.pop_front());
          m_data = 4'(s);
          m_tv   = 1'b1;
        end
      end
      if (acc) begin
        n = (int'(in_len) > IN_W) ? IN_W : int'(in_len);
        for (int i = n - 1; i >= 0; i--) mq.push_back(in_bits[i]);
      end
      if (!m_err) begin
        st = parse(l, s);
        if (st == 2) m_err = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("sReady", int'(sReady), int'(m_ready()));
    check("tvalid", int'(tvalid), int'(m_tv));
    check("err", int'(err), int'(m_err));
    if (m_tv) check("decodedData", int'(decodedData), int'(m_data));
`ifdef HUFF_SYMCNT_EN
    check("sym_count", int'(sym_count), m_hs_cnt & 32'hFFFF);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [IN_W-1:0] b, input int len);
    bit r;
    bit done = 1'b0;
    sValid  = 1'b1;
    in_bits = b;
    in_len  = LW'(len);
    for (int c = 0; c < 100 && !done; c++) begin
      r = m_ready();
      tick();
      if (r) done = 1'b1;
    end
    if (!done) check("send_timeout", 0, 1);
    sValid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_log.delete();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    int syms[$];
    bit gq[$];
    int ptr, cyc, req, n, s, k;
    bit sv, r;

    sValid = 1'b0; in_bits = '0; in_len = '0; tready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_sReady", int'(sReady), 0);
    check("rst_tvalid", int'(tvalid), 0);
    check("rst_err", int'(err), 0);
    check("rst_data", int'(decodedData), 0);
    reset = 1'b0;
    tick();
    check("idle_sReady", int'(sReady), 1);

    // "1010": -1 then 0 on consecutive cycles, one cycle after the codeword completes
    do_reset();
    tready = 1'b1;
    send(4'b1010, 4);
    check("s1_no_out_yet", int'(tvalid), 0);
    tick();
    check("s1_v1", int'(tvalid), 1);
    check("s1_d1", int'(decodedData), -1);
    tick();
    check("s1_v2", int'(tvalid), 1);
    check("s1_d2", int'(decodedData), 0);
    tick();
    check("s1_v3", int'(tvalid), 0);
    check("s1_log_n", m_log.size(), 2);
    if (m_log.size() == 2) begin
      check("s1_log0", m_log[0], -1);
      check("s1_log1", m_log[1], 0);
    end
    check("s1_bits_left", mq.size(), 0);

    // "111" then "1100" -> single symbol 5
    do_reset();
    tready = 1'b1;
    send(4'b0111, 3);
    repeat (4) tick();
    check("s2_none_yet", m_log.size(), 0);
    check("s2_tvalid_low", int'(tvalid), 0);
    send(4'b1100, 4);
    repeat (4) tick();
    check("s2_log_n", m_log.size(), 1);
    if (m_log.size() == 1) check("s2_sym", m_log[0], 5);

    // Back-pressure with zeros, then release
    do_reset();
    tready = 1'b0;
    repeat (4) send(4'b0000, 4);
    sValid = 1'b1; in_bits = 4'b0000; in_len = LW'(4);
    repeat (3) tick();
    check("s3_buffered", mq.size(), 15);
    check("s3_sReady", int'(sReady), 0);
    check("s3_tvalid", int'(tvalid), 1);
    check("s3_data", int'(decodedData), 0);
    check("s3_no_hs", m_log.size(), 0);
    tready = 1'b1;
    send(4'b0000, 4);
    repeat (30) tick();
    check("s3_total", m_log.size(), 20);
    k = 0;
    foreach (m_log[i]) if (m_log[i] != 0) k++;
    check("s3_nonzero", k, 0);

    // Nine ones -> sticky error, nothing decoded
    do_reset();
    tready = 1'b1;
    send(4'b1111, 4);
    send(4'b1111, 4);
    send(4'b0001, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s4_err", int'(err), 1);
      check("s4_sReady", int'(sReady), 0);
      check("s4_tvalid", int'(tvalid), 0);
    end
    check("s4_no_syms", m_log.size(), 0);

    // Asynchronous reset with a pending symbol and a partial codeword
    do_reset();
    tready = 1'b0;
    send(4'b0111, 4);
    tick();
    check("s5_pending", int'(tvalid), 1);
    #1 reset = 1'b1;
    #1;
    check("s5_async_tvalid", int'(tvalid), 0);
    check("s5_async_sReady", int'(sReady), 0);
    check("s5_async_err", int'(err), 0);
    check("s5_async_data", int'(decodedData), 0);
    tick();
    reset = 1'b0;
    m_log.delete();
    tick();
    tready = 1'b1;
    send(4'b0000, 1);
    repeat (4) tick();
    check("s5_log_n", m_log.size(), 1);
    if (m_log.size() == 1) check("s5_sym", m_log[0], 0);

    // Randomized: valid symbol stream, random chunking, garbage above in_len, random back-pressure
    do_reset();
    for (int i = 0; i < 300; i++) begin
      s = int'($urandom_range(15)) - 8;
      syms.push_back(s);
      k = (s < 0) ? -s : s;
      if (s == 0) gq.push_back(1'b0);
      else if (s == -8) begin
        repeat (8) gq.push_back(1'b1);
        gq.push_back(1'b0);
      end else begin
        repeat (k) gq.push_back(1'b1);
        gq.push_back(1'b0);
        gq.push_back(s < 0);
      end
    end
    ptr = 0;
    cyc = 0;
    while (ptr < gq.size() && cyc < 20000) begin
      sv  = ($urandom_range(3) != 0);
      req = int'($urandom_range(7));
      n   = (req > IN_W) ? IN_W : req;
      if (n > gq.size() - ptr) begin
        n = gq.size() - ptr;
        req = n;
      end
      in_bits = IN_W'($urandom);
      for (int i = 0; i < n; i++) in_bits[n-1-i] = gq[ptr+i];
      in_len = LW'(req);
      sValid = sv;
      tready = ($urandom_range(9) < 7);
      r = m_ready();
      tick();
      cyc++;
      if (sv && r) ptr += n;
    end
    if (ptr < gq.size()) check("rand_feed_timeout", ptr, gq.size());
    sValid = 1'b0;
    tready = 1'b1;
    repeat (80) tick();
    check("rand_count", m_log.size(), syms.size());
    if (m_log.size() == syms.size()) begin
      foreach (syms[i]) check("rand_sym", m_log[i], syms[i]);
    end
    check("rand_no_err", int'(err), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
